// File: rtl/circle_plotter.sv
// Midpoint circle rasteriser for a small VGA frame buffer.
// One start captures the circle parameters; the block then walks the
// first octant with the midpoint algorithm and emits the eight mirrored
// candidate pixels per step, suppressing plot for off-screen candidates.
//
// Handshake: start is a single-cycle request that is only looked at while
// the block is idle (busy=0); requests while busy are dropped, not queued.
// x/y/colour are meaningful only in cycles where plot=1, and done pulses
// for exactly one cycle after the last pixel of a circle.
module circle_plotter #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cx,
  input  logic [6:0] cy,
  input  logic [6:0] radius,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_PLOT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [6:0]        r_q, r_d;
  logic [2:0]        col_q, col_d;
  // xo can go negative (radius 0 steps to -1), so offsets are signed.
  logic signed [8:0] xo_q, xo_d;
  logic signed [8:0] yo_q, yo_d;
  logic signed [9:0] d_q, d_d;
  logic [2:0]        oct_q, oct_d;

  logic signed [8:0] cx_s, cy_s;
  logic signed [8:0] px, py;
  logic              in_range;
  logic signed [8:0] yo_new, xo_new;
  logic signed [9:0] yo_w, xo_w, d_new;

  assign cx_s = {1'b0, cx_q};
  assign cy_s = {2'b00, cy_q};

  // Candidate pixel for the current octant, in 9-bit signed arithmetic.
  always_comb begin
    px = cx_s;
    py = cy_s;
    case (oct_q)
      3'd0: begin px = cx_s + xo_q; py = cy_s + yo_q; end
      3'd1: begin px = cx_s + yo_q; py = cy_s + xo_q; end
      3'd2: begin px = cx_s - yo_q; py = cy_s + xo_q; end
      3'd3: begin px = cx_s - xo_q; py = cy_s + yo_q; end
      3'd4: begin px = cx_s - xo_q; py = cy_s - yo_q; end
      3'd5: begin px = cx_s - yo_q; py = cy_s - xo_q; end
      3'd6: begin px = cx_s + yo_q; py = cy_s - xo_q; end
      default: begin px = cx_s + xo_q; py = cy_s - yo_q; end
    endcase
    in_range = (int'(px) >= 0) && (int'(px) < SCREEN_WIDTH) &&
               (int'(py) >= 0) && (int'(py) < SCREEN_HEIGHT);
  end

  // Midpoint decision step applied at the end of each eight-pixel pass.
  always_comb begin
    yo_new = yo_q + 9'sd1;
    xo_new = (d_q < 0) ? xo_q : (xo_q - 9'sd1);
    yo_w   = {yo_new[8], yo_new};
    xo_w   = {xo_new[8], xo_new};
    if (d_q < 0) d_new = d_q + (yo_w <<< 1) + 10'sd1;
    else         d_new = d_q + ((yo_w - xo_w) <<< 1) + 10'sd1;
  end

  // State register and datapath flops; reset aborts any circle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      col_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      d_q     <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      col_q   <= col_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      d_q     <= d_d;
      oct_q   <= oct_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    r_d       = r_q;
    col_d     = col_q;
    xo_d      = xo_q;
    yo_d      = yo_q;
    d_d       = d_q;
    oct_d     = oct_q;
    x         = '0;
    y         = '0;
    colour    = '0;
    plot      = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    state_dbg = state_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          r_d     = radius;
          col_d   = colour_in;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        xo_d    = {2'b00, r_q};
        yo_d    = '0;
        d_d     = 10'sd1 - $signed({3'b000, r_q});
        oct_d   = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        x      = px[7:0];
        y      = py[6:0];
        colour = col_q;
        plot   = in_range;
        oct_d  = oct_q + 3'd1;
        if (oct_q == 3'd7) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        yo_d    = yo_new;
        xo_d    = xo_new;
        d_d     = d_new;
        oct_d   = '0;
        state_d = (yo_new > xo_new) ? S_DONE : S_PLOT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_circle_plotter.sv
// Directed bench for circle_plotter: a midpoint reference model fills an
// expected-pixel queue when each circle is started, and a negedge monitor
// pops and compares on every plot strobe.
module tb_circle_plotter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] cx_in;
  logic [6:0] cy_in;
  logic [6:0] radius_in;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  circle_plotter #(.SCREEN_WIDTH(160), .SCREEN_HEIGHT(120)) dut (
    .clk(clk), .reset(reset), .start(start), .cx(cx_in), .cy(cy_in),
    .radius(radius_in), .colour_in(colour_in), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference midpoint circle: pushes visible pixels, returns pass count.
  task automatic push_circle(input int cxv, input int cyv, input int rv,
                             input int colv, output int passes);
    int xo, yo, d, px, py;
    logic [17:0] e;
    xo = rv; yo = 0; d = 1 - rv; passes = 0;
    do begin
      passes++;
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cxv + xo; py = cyv + yo; end
          1: begin px = cxv + yo; py = cyv + xo; end
          2: begin px = cxv - yo; py = cyv + xo; end
          3: begin px = cxv - xo; py = cyv + yo; end
          4: begin px = cxv - xo; py = cyv - yo; end
          5: begin px = cxv - yo; py = cyv - xo; end
          6: begin px = cxv + yo; py = cyv - xo; end
          default: begin px = cxv + xo; py = cyv - yo; end
        endcase
        if (px >= 0 && px < 160 && py >= 0 && py < 120) begin
          e = {px[7:0], py[6:0], colv[2:0]};
          exp_q.push_back(e);
        end
      end
      yo = yo + 1;
      if (d < 0) d = d + 2 * yo + 1;
      else begin
        xo = xo - 1;
        d = d + 2 * (yo - xo) + 1;
      end
    end while (yo <= xo);
  endtask

  // Monitor: compare every plotted pixel against the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (plot) begin
        if (exp_q.size() == 0) check("unexpected_plot", 32'd1, 32'd0);
        else check("pixel", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
      end
      if (done) done_cnt++;
    end
  end

  // Start a circle and follow it to done; optional re-pulse with a new cx.
  task automatic run_circle(input string tag, input int cxv, input int cyv,
                            input int rv, input int colv, input bit skip_wait,
                            input int repulse_at);
    int passes, k, d0;
    bit seen;
    d0 = done_cnt;
    push_circle(cxv, cyv, rv, colv, passes);
    if (!skip_wait) @(negedge clk);
    cx_in = 8'(cxv); cy_in = 7'(cyv); radius_in = 7'(rv); colour_in = 3'(colv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_init_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_init_state"}, {29'd0, state_dbg}, 32'd1);
    k = 1; seen = 0;
    while (k < 2000 && !seen) begin
      @(negedge clk);
      k++;
      if (done) seen = 1;
      else if (k == repulse_at) begin
        start = 1'b1; cx_in = 8'd20; cy_in = 7'd5; radius_in = 7'd3;
      end else start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_done_cycle"}, k, 2 + 9 * passes);
    check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_state"}, {29'd0, state_dbg}, 32'd0);
    check({tag, "_one_done"}, done_cnt - d0, 32'd1);
    exp_q.delete();
  endtask

  initial begin
    int passes, d0;
    reset = 1'b1; start = 1'b0;
    cx_in = 8'd80; cy_in = 7'd60; radius_in = 7'd5; colour_in = 3'd7;
    repeat (3) @(negedge clk);
    start = 1'b1;
    #1;
    check("rst_plot", {31'd0, plot}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_xyc", {14'd0, x, y, colour}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;

    // Radius 0 right at the first edge after reset.
    run_circle("r0", 80, 60, 0, 1, 1'b1, 0);
    // Radius 1: ordered pixel check via the queue.
    run_circle("r1", 80, 60, 1, 2, 1'b0, 0);
    // Heavy clipping in the top-left corner.
    run_circle("clip", 0, 0, 5, 5, 1'b0, 0);
    // Bottom-right clipping.
    run_circle("clip_br", 159, 119, 7, 6, 1'b0, 0);
    // Re-pulse start with changed inputs mid-draw.
    run_circle("repulse", 80, 60, 10, 4, 1'b0, 5);
    repeat (3) @(negedge clk);
    check("no_queued_start", {31'd0, busy}, 32'd0);

    // Random circles.
    for (int i = 0; i < 4; i++)
      run_circle("rand", $urandom_range(0, 159), $urandom_range(0, 119),
                 $urandom_range(0, 40), $urandom_range(0, 7), 1'b0, 0);

    // Abort a radius-20 circle with an asynchronous reset during PLOT.
    d0 = done_cnt;
    push_circle(80, 60, 20, 3, passes);
    @(negedge clk);
    cx_in = 8'd80; cy_in = 7'd60; radius_in = 7'd20; colour_in = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_in_plot", {29'd0, state_dbg}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("abort_plot", {31'd0, plot}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_xyc", {14'd0, x, y, colour}, 32'd0);
    check("abort_state", {29'd0, state_dbg}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_circle("post_abort", 80, 60, 20, 3, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
